// File: rtl/multicycle_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_seq
// Description : Multi-cycle IF->ID->EX->[MEM]->WB control sequencer for a
//               single-issue RV64I core, with stall timeout and halt causes.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_seq #(
  parameter int XLEN        = 64,
  parameter int STALL_LIMIT = 255,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             ifu_finish,
  input  logic             exu_finish,
  input  logic             memu_finish,
  output logic             ifu_valid,
  output logic             idu_valid,
  output logic             exu_valid,
  output logic             memu_valid,
  output logic             wb_valid,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       alu_op,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       br_sel,
  output logic             mem_re,
  output logic             mem_we,
  output logic             rf_we,
  output logic             retire,
  output logic             halted,
  output logic             illegal_instr,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_op32   = 7'b0111011;
  localparam logic [6:0] c_op_opim32 = 7'b0011011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [31:0] c_ebreak   = 32'h0010_0073;

  localparam logic [4:0] c_alu_add  = 5'd0;
  localparam logic [4:0] c_alu_sub  = 5'd1;
  localparam logic [4:0] c_alu_pass = 5'd20;

  localparam bit c_rv64  = (XLEN == 64);
  localparam bit c_to_en = (STALL_LIMIT != 0);
  localparam int c_stall_w = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [c_stall_w-1:0] c_stall_limit = c_stall_w'(STALL_LIMIT);

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [31:0]          r_instr;
  logic [c_stall_w-1:0] r_stall;
  logic [CNT_W-1:0]     r_instret;
  logic                 r_illegal;
  logic                 r_timeout;

  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_alu_op;
  logic [1:0]      r_a_sel;
  logic [1:0]      r_b_sel;
  logic [1:0]      r_br_sel;
  logic            r_mem_re;
  logic            r_mem_we;
  logic            r_wr;

  logic            w_legal;
  logic            w_ebreak;
  logic            w_wr;
  logic [4:0]      w_alu_op;
  logic [1:0]      w_a_sel;
  logic [1:0]      w_b_sel;
  logic [1:0]      w_br_sel;
  logic            w_mem_re;
  logic            w_mem_we;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_waiting;
  logic            w_fin;
  logic            w_to_fire;

  function automatic logic [4:0] f_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    f_alu = alt ? c_alu_sub : c_alu_add;
      3'd1:    f_alu = 5'd5;
      3'd2:    f_alu = 5'd8;
      3'd3:    f_alu = 5'd9;
      3'd4:    f_alu = 5'd4;
      3'd5:    f_alu = alt ? 5'd7 : 5'd6;
      3'd6:    f_alu = 5'd3;
      default: f_alu = 5'd2;
    endcase
  endfunction

  // Decode works on the latched word; its results are captured on ID->EX.
  always_comb begin
    w_legal  = 1'b0;
    w_ebreak = 1'b0;
    w_wr     = 1'b0;
    w_alu_op = c_alu_add;
    w_a_sel  = 2'd0;
    w_b_sel  = 2'd0;
    w_br_sel = 2'd0;
    w_mem_re = 1'b0;
    w_mem_we = 1'b0;
    w_imm32  = 32'd0;
    case (r_instr[6:0])
      c_op_op, c_op_op32: begin
        w_legal  = (r_instr[6:0] == c_op_op) || c_rv64;
        w_wr     = 1'b1;
        w_alu_op = f_alu(r_instr[14:12], r_instr[30]);
      end
      c_op_opimm, c_op_opim32: begin
        w_legal  = (r_instr[6:0] == c_op_opimm) || c_rv64;
        w_wr     = 1'b1;
        w_b_sel  = 2'd1;
        w_imm32  = {{20{r_instr[31]}}, r_instr[31:20]};
        w_alu_op = f_alu(r_instr[14:12], (r_instr[14:12] == 3'd5) && r_instr[30]);
      end
      c_op_lui: begin
        w_legal  = 1'b1;
        w_wr     = 1'b1;
        w_b_sel  = 2'd1;
        w_alu_op = c_alu_pass;
        w_imm32  = {r_instr[31:12], 12'd0};
      end
      c_op_auipc: begin
        w_legal  = 1'b1;
        w_wr     = 1'b1;
        w_a_sel  = 2'd1;
        w_b_sel  = 2'd1;
        w_imm32  = {r_instr[31:12], 12'd0};
      end
      c_op_jal: begin
        w_legal  = 1'b1;
        w_wr     = 1'b1;
        w_a_sel  = 2'd1;
        w_b_sel  = 2'd2;
        w_br_sel = 2'd1;
        w_imm32  = {{12{r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
      end
      c_op_jalr: begin
        w_legal  = (r_instr[14:12] == 3'd0);
        w_wr     = 1'b1;
        w_a_sel  = 2'd1;
        w_b_sel  = 2'd2;
        w_br_sel = 2'd2;
        w_imm32  = {{20{r_instr[31]}}, r_instr[31:20]};
      end
      c_op_branch: begin
        w_legal  = (r_instr[14:12] != 3'd2) && (r_instr[14:12] != 3'd3);
        w_br_sel = 2'd3;
        w_alu_op = c_alu_sub;
        w_imm32  = {{20{r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
      end
      c_op_load: begin
        w_legal  = 1'b1;
        w_wr     = 1'b1;
        w_mem_re = 1'b1;
        w_b_sel  = 2'd1;
        w_imm32  = {{20{r_instr[31]}}, r_instr[31:20]};
      end
      c_op_store: begin
        w_legal  = 1'b1;
        w_mem_we = 1'b1;
        w_b_sel  = 2'd1;
        w_imm32  = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      end
      default: begin
        w_ebreak = (r_instr == c_ebreak);
      end
    endcase
    w_imm       = {XLEN{w_imm32[31]}};
    w_imm[31:0] = w_imm32;
  end

  assign w_waiting = (r_state == S_IF) || (r_state == S_EX) || (r_state == S_MEM);
  assign w_fin     = ((r_state == S_IF)  && ifu_finish) ||
                     ((r_state == S_EX)  && exu_finish) ||
                     ((r_state == S_MEM) && memu_finish);
  assign w_to_fire = c_to_en && w_waiting && !w_fin && (r_stall == c_stall_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF:    if (ifu_finish) w_next = S_ID;
               else if (w_to_fire) w_next = S_HALT;
      S_ID:    w_next = w_legal ? S_EX : S_HALT;
      S_EX:    if (exu_finish) w_next = (r_mem_re || r_mem_we) ? S_MEM : S_WB;
               else if (w_to_fire) w_next = S_HALT;
      S_MEM:   if (memu_finish) w_next = S_WB;
               else if (w_to_fire) w_next = S_HALT;
      S_WB:    w_next = S_IF;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= 32'd0;
      r_stall   <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_imm     <= '0;
      r_alu_op  <= 5'd0;
      r_a_sel   <= 2'd0;
      r_b_sel   <= 2'd0;
      r_br_sel  <= 2'd0;
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      if ((r_state == S_IF) && ifu_finish) r_instr <= instr;
      // Counter restarts on every state change, so entering a wait state sees 0.
      if (r_state != w_next) r_stall <= '0;
      else if (w_waiting)    r_stall <= r_stall + c_stall_w'(1);
      if (r_state == S_WB) r_instret <= r_instret + CNT_W'(1);
      if ((r_state == S_ID) && !w_legal && !w_ebreak) r_illegal <= 1'b1;
      if (w_to_fire) r_timeout <= 1'b1;
      if ((r_state == S_ID) && w_legal) begin
        r_imm    <= w_imm;
        r_alu_op <= w_alu_op;
        r_a_sel  <= w_a_sel;
        r_b_sel  <= w_b_sel;
        r_br_sel <= w_br_sel;
        r_mem_re <= w_mem_re;
        r_mem_we <= w_mem_we;
        r_wr     <= w_wr;
      end
    end
  end

  always_comb begin
    ifu_valid     = (r_state == S_IF);
    idu_valid     = (r_state == S_ID);
    exu_valid     = (r_state == S_EX);
    memu_valid    = (r_state == S_MEM);
    wb_valid      = (r_state == S_WB);
    halted        = (r_state == S_HALT);
    retire        = (r_state == S_WB);
    rf_we         = (r_state == S_WB) && r_wr && (r_instr[11:7] != 5'd0);
    rs1_addr      = r_instr[19:15];
    rs2_addr      = r_instr[24:20];
    rd_addr       = r_instr[11:7];
    imm           = r_imm;
    alu_op        = r_alu_op;
    alu_a_sel     = r_a_sel;
    alu_b_sel     = r_b_sel;
    br_sel        = r_br_sel;
    mem_re        = r_mem_re;
    mem_we        = r_mem_we;
    illegal_instr = r_illegal;
    timeout_err   = r_timeout;
    instret       = r_instret;
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_seq
// Description : Directed scoreboard bench for multicycle_ctrl_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        ifu_finish, exu_finish, memu_finish;
  logic        ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, alu_op;
  logic [63:0] imm;
  logic [1:0]  alu_a_sel, alu_b_sel, br_sel;
  logic        mem_re, mem_we, rf_we, retire, halted, illegal_instr, timeout_err;
  logic [63:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl_seq #(.XLEN(64), .STALL_LIMIT(4), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .ifu_finish(ifu_finish), .exu_finish(exu_finish), .memu_finish(memu_finish),
    .ifu_valid(ifu_valid), .idu_valid(idu_valid), .exu_valid(exu_valid),
    .memu_valid(memu_valid), .wb_valid(wb_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .br_sel(br_sel), .mem_re(mem_re), .mem_we(mem_we), .rf_we(rf_we),
    .retire(retire), .halted(halted), .illegal_instr(illegal_instr),
    .timeout_err(timeout_err), .instret(instret)
  );

  typedef struct {
    logic [31:0] ins;
    logic [63:0] imm;
    logic [4:0]  alu;
    bit          chk_alu;
    logic [1:0]  a_sel, b_sel, br;
    logic        re, we;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_instret = 64'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [63:0] im, input logic [4:0] alu,
                      input bit chk, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] br, input logic re, input logic we);
    exp_t e;
    e.ins = ins; e.imm = im; e.alu = alu; e.chk_alu = chk;
    e.a_sel = a; e.b_sel = b; e.br = br; e.re = re; e.we = we;
    sb.push_back(e);
  endtask

  // Plays the IFU/EXU/MEMU roles for one instruction; compares the queued
  // expectation when WB is observed.
  task automatic run_instr(input logic [31:0] ins, input int ex_dly, input int mem_dly,
                           output int cyc, output int n_ex, output int n_mem,
                           output int rfwe_n, output int ret_n, output int memre_n,
                           output bit saw_wb, output bit saw_halt);
    exp_t e;
    cyc = 0; n_ex = 0; n_mem = 0; rfwe_n = 0; ret_n = 0; memre_n = 0;
    saw_wb = 0; saw_halt = 0;
    instr = ins;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if (rf_we)  rfwe_n++;
      if (retire) ret_n++;
      if (halted) begin
        saw_halt = 1;
        break;
      end
      if (wb_valid) begin
        saw_wb = 1;
        if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check("imm", imm, e.imm);
          if (e.chk_alu) begin
            check("alu_op", 64'(alu_op), 64'(e.alu));
            check("alu_a_sel", 64'(alu_a_sel), 64'(e.a_sel));
          end
          check("alu_b_sel", 64'(alu_b_sel), 64'(e.b_sel));
          check("br_sel", 64'(br_sel), 64'(e.br));
          check("mem_re", 64'(mem_re), 64'(e.re));
          check("mem_we", 64'(mem_we), 64'(e.we));
          check("rd_addr", 64'(rd_addr), 64'(e.ins[11:7]));
          check("rs1_addr", 64'(rs1_addr), 64'(e.ins[19:15]));
        end
      end
      ifu_finish  = ifu_valid;
      exu_finish  = exu_valid && (n_ex >= ex_dly);
      memu_finish = memu_valid && (n_mem >= mem_dly);
      if (exu_valid) n_ex++;
      if (memu_valid) begin
        n_mem++;
        if (mem_re) memre_n++;
      end
      if (wb_valid) break;
    end
  endtask

  task automatic normal(input logic [31:0] ins, input int ex_dly, input int mem_dly,
                        input int exp_cyc, input int exp_rfwe, input int exp_mem,
                        input int exp_memre);
    int cyc, n_ex, n_mem, rfwe_n, ret_n, memre_n;
    bit saw_wb, saw_halt;
    run_instr(ins, ex_dly, mem_dly, cyc, n_ex, n_mem, rfwe_n, ret_n, memre_n, saw_wb, saw_halt);
    check("reached_wb", 64'(saw_wb), 64'd1);
    check("latency", 64'(cyc), 64'(exp_cyc));
    check("rf_we_pulses", 64'(rfwe_n), 64'(exp_rfwe));
    check("retire_pulses", 64'(ret_n), 64'd1);
    check("mem_cycles", 64'(n_mem), 64'(exp_mem));
    check("mem_re_in_mem", 64'(memre_n), 64'(exp_memre));
    exp_instret++;
    @(posedge clk); #1;
    check("instret", instret, exp_instret);
    check("back_in_if", 64'(ifu_valid), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifu_finish = 1'b0; exu_finish = 1'b0; memu_finish = 1'b0;
    #1;
    check("rst_ifu_valid", 64'(ifu_valid), 64'd1);
    check("rst_flags", {59'd0, halted, illegal_instr, timeout_err, mem_re, rf_we}, 64'd0);
    check("rst_instret", instret, 64'd0);
    exp_instret = 64'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n_ex, n_mem, rfwe_n, ret_n, memre_n, nm;
    bit saw_wb, saw_halt;
    logic [63:0] ir_before;

    rst = 1'b1; instr = 32'd0;
    ifu_finish = 1'b0; exu_finish = 1'b0; memu_finish = 1'b0;
    #1;
    check("reset_ifu_valid", 64'(ifu_valid), 64'd1);
    check("reset_other_valids", {59'd0, idu_valid, exu_valid, memu_valid, wb_valid, halted}, 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_ctrl", {48'd0, imm[15:0]}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,5
    push(32'h0050_0093, 64'd5, 5'd0, 1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0);
    normal(32'h0050_0093, 0, 0, 4, 1, 0, 0);
    // ld x2,8(x1), MEM finish on 4th MEM cycle
    push(32'h0080_B103, 64'd8, 5'd0, 1, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0);
    normal(32'h0080_B103, 0, 3, 8, 1, 4, 4);
    // beq x0,x0,-4
    push(32'hFE00_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0);
    normal(32'hFE00_0EE3, 0, 0, 4, 0, 0, 0);
    // add / sub / xor x?,x1,x2
    push(32'h0020_81B3, 64'd0, 5'd0, 1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    normal(32'h0020_81B3, 0, 0, 4, 1, 0, 0);
    push(32'h4020_81B3, 64'd0, 5'd1, 1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    normal(32'h4020_81B3, 0, 0, 4, 1, 0, 0);
    push(32'h0020_C333, 64'd0, 5'd4, 1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    normal(32'h0020_C333, 0, 0, 4, 1, 0, 0);
    // lui x4,0x80000: U-immediate sign-extended to 64 bits
    push(32'h8000_0237, 64'hFFFF_FFFF_8000_0000, 5'd20, 0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0);
    normal(32'h8000_0237, 0, 0, 4, 1, 0, 0);
    // sd x2,-8(x1)
    push(32'hFE20_BC23, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1);
    normal(32'hFE20_BC23, 0, 0, 5, 0, 1, 0);
    // addi x0,x0,1: retires but no register write
    push(32'h0010_0013, 64'd1, 5'd0, 1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0);
    normal(32'h0010_0013, 0, 0, 4, 0, 0, 0);
    // jal x1,16
    push(32'h0100_00EF, 64'd16, 5'd0, 1, 2'd1, 2'd2, 2'd1, 1'b0, 1'b0);
    normal(32'h0100_00EF, 0, 0, 4, 1, 0, 0);
    // addi x7,x0,-1 with exu_finish on the 5th EX cycle (limit cycle): finish wins
    push(32'hFFF0_0393, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0);
    normal(32'hFFF0_0393, 4, 0, 8, 1, 0, 0);
    check("no_timeout_on_limit_finish", 64'(timeout_err), 64'd0);

    // Illegal word halts after ID and ignores later finishes
    run_instr(32'hFFFF_FFFF, 0, 0, cyc, n_ex, n_mem, rfwe_n, ret_n, memre_n, saw_wb, saw_halt);
    check("illegal_halt_seen", 64'(saw_halt), 64'd1);
    check("illegal_halt_cycle", 64'(cyc), 64'd3);
    check("illegal_flags", {61'd0, halted, illegal_instr, timeout_err}, 64'd6);
    ifu_finish = 1'b1; exu_finish = 1'b1; memu_finish = 1'b1;
    repeat (3) @(negedge clk);
    check("halt_valids", {59'd0, ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid}, 64'd0);
    check("halt_sticky", 64'(halted), 64'd1);
    check("halt_instret", instret, exp_instret);
    check("halt_no_rfwe", {62'd0, rf_we, retire}, 64'd0);

    // ebreak halts without the illegal flag and is not counted
    do_reset();
    run_instr(32'h0010_0073, 0, 0, cyc, n_ex, n_mem, rfwe_n, ret_n, memre_n, saw_wb, saw_halt);
    check("ebreak_halt_cycle", 64'(cyc), 64'd3);
    check("ebreak_flags", {61'd0, halted, illegal_instr, timeout_err}, 64'd4);
    check("ebreak_instret", instret, 64'd0);

    // Async reset in the middle of MEM aborts the load
    do_reset();
    instr = 32'h0080_B103;
    nm = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (memu_valid) nm++;
      if (nm == 2) break;
      ifu_finish = ifu_valid; exu_finish = exu_valid; memu_finish = 1'b0;
    end
    check("mem_reached", 64'(nm), 64'd2);
    check("mem_re_before_rst", 64'(mem_re), 64'd1);
    ir_before = instret;
    #2 rst = 1'b1;
    #1;
    check("midrst_ifu_valid", 64'(ifu_valid), 64'd1);
    check("midrst_state", {61'd0, memu_valid, wb_valid, mem_re}, 64'd0);
    check("midrst_no_retire", {62'd0, rf_we, retire}, 64'd0);
    check("midrst_instret", instret, ir_before);
    @(negedge clk);
    rst = 1'b0; exp_instret = 64'd0;
    push(32'h0050_0093, 64'd5, 5'd0, 1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0);
    normal(32'h0050_0093, 0, 0, 4, 1, 0, 0);

    // exu_finish never: HALT after 5 EX cycles with timeout
    run_instr(32'h0050_0093, 1000, 0, cyc, n_ex, n_mem, rfwe_n, ret_n, memre_n, saw_wb, saw_halt);
    check("timeout_halt_seen", 64'(saw_halt), 64'd1);
    check("timeout_ex_cycles", 64'(n_ex), 64'd5);
    check("timeout_no_wb", 64'(saw_wb), 64'd0);
    check("timeout_flags", {61'd0, halted, illegal_instr, timeout_err}, 64'd5);
    check("timeout_instret", instret, exp_instret);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
